// File: rtl/dma_bus_if.sv
// dma_bus_if: bus bundle between the CPU, the DMA block-copy arbiter and the memory port
//   cpu_*  CPU bus cycle (address, strobe 1=read, write data) and the halt that freezes it
//   dma_*  start request, source page, destination, busy and done status
//   mem_*  memory port (address, strobe 1=read, write data) and its same-cycle read data
// Modport master belongs to the arbiter; modport slave is the surrounding system.
interface dma_bus_if;
  logic [15:0] cpu_address;
  logic        cpu_read_write;
  logic [7:0]  cpu_data_write;
  logic        cpu_halt;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic [15:0] dma_dest;
  logic        dma_busy;
  logic        dma_done;
  logic [7:0]  mem_data_read;
  logic [15:0] mem_address;
  logic        mem_read_write;
  logic [7:0]  mem_data_write;
  modport master (
    input  cpu_address, cpu_read_write, cpu_data_write,
    input  dma_start, dma_page, dma_dest,
    input  mem_data_read,
    output cpu_halt, dma_busy, dma_done,
    output mem_address, mem_read_write, mem_data_write
  );
  modport slave (
    output cpu_address, cpu_read_write, cpu_data_write,
    output dma_start, dma_page, dma_dest,
    output mem_data_read,
    input  cpu_halt, dma_busy, dma_done,
    input  mem_address, mem_read_write, mem_data_write
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: passes CPU bus cycles to memory, or halts the CPU and copies a page-aligned block
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  dma_bus_if.master: cpu_* in / cpu_halt out, dma_* request and status, mem_* port
// Parameters: BLOCK_LEN bytes per copy (1..256), DEST_INC 1 = destination advances per byte.
module dma_bus_arbiter #(
  parameter int BLOCK_LEN = 256,
  parameter bit DEST_INC  = 1'b0
) (
  input logic      clk,
  input logic      rst,
  dma_bus_if.master bus
);
  typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;
  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);
  state_t      state, state_nx;
  logic [7:0]  page, idx, data;
  logic [15:0] dest;
  logic        done_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      data   <= 8'h00;
      dest   <= 16'h0000;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= state == DONE;
      if (state == IDLE && bus.dma_start) begin
        page <= bus.dma_page;
        dest <= bus.dma_dest;
        idx  <= 8'h00;
      end
      if (state == READ) data <= bus.mem_data_read;
      if (state == WRITE) begin
        idx <= idx + 8'd1;
        if (DEST_INC) dest <= dest + 16'd1;
      end
    end
  end
  // WAIT lets an in-flight CPU write finish; the bus is taken only after a read cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.dma_start ? WAIT : IDLE;
      WAIT:    state_nx = bus.cpu_read_write ? READ : WAIT;
      READ:    state_nx = WRITE;
      WRITE:   state_nx = idx == LAST ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.mem_address    = state == READ ? {page, idx} : state == WRITE ? dest : bus.cpu_address;
    bus.mem_read_write = state == READ ? 1'b1 : state == WRITE ? 1'b0 : bus.cpu_read_write;
    bus.mem_data_write = state == WRITE ? data : bus.cpu_data_write;
    bus.cpu_halt       = state != IDLE;
    bus.dma_busy       = state != IDLE;
    bus.dma_done       = done_q;
  end
endmodule
